// File: rtl/act_lane_pipe_if.sv
// Stream bundle for the activation lane stage: input vectors from the read
// buffer and output vectors toward the write DMA.
interface act_lane_pipe_if #(
  parameter int unsigned LANES = 8,
  parameter int unsigned DW    = 16
);
  logic                  in_vld;
  logic                  in_rdy;
  logic [LANES*DW-1:0]   in_dat;
  logic                  out_vld;
  logic                  out_rdy;
  logic [LANES*DW-1:0]   out_dat;

  // Upstream/downstream agent view
  modport master (
    output in_vld, in_dat, out_rdy,
    input  in_rdy, out_vld, out_dat
  );

  // Activation stage view
  modport slave (
    input  in_vld, in_dat, out_rdy,
    output in_rdy, out_vld, out_dat
  );
endinterface

// File: rtl/act_lane_pipe.sv
// Multi-lane activation stage: per-lane bypass/ReLU/leaky-ReLU/requantise
// through a fixed-latency pipeline into a credit-protected FWFT FIFO, with a
// start/done frame counter bounding each job to num_vec vectors.
module act_lane_pipe #(
  parameter int unsigned LANES      = 8,
  parameter int unsigned DW         = 16,
  parameter int unsigned LAT        = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LOG2_DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [2:0]  shift,
  input  logic [15:0] num_vec,
  act_lane_pipe_if.slave bus,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CW = LOG2_DEPTH + 1;

  logic                 r_busy, r_done;
  logic [1:0]           r_mode;
  logic [2:0]           r_shift;
  logic [15:0]          r_num, r_in_cnt, r_out_cnt;
  logic [CW-1:0]        r_credit;
  logic [LAT-1:0]       r_pvld;
  logic [LANES*DW-1:0]  r_pdat [LAT];
  logic [LANES*DW-1:0]  r_mem  [FIFO_DEPTH];
  logic [LOG2_DEPTH-1:0] r_wptr, r_rptr;
  logic [CW-1:0]        r_count;

  logic                 w_acc, w_pop, w_wr, w_out_vld;
  logic [LANES*DW-1:0]  w_f;

  function automatic logic [DW-1:0] f_lane(input logic [DW-1:0] x,
                                           input logic [1:0] m,
                                           input logic [2:0] sh);
    logic signed [DW-1:0] sx;
    logic signed [DW:0]   sum;
    sx     = x;
    sum    = '0;
    f_lane = x;
    case (m)
      2'd1: if (sx[DW-1]) f_lane = '0;
      2'd2: if (sx[DW-1]) f_lane = sx >>> 3;
      2'd3: if (sh != 3'd0) begin
        // One extra bit of headroom so the rounding add cannot wrap
        sum    = {sx[DW-1], sx} + ((DW+1)'(1) << (sh - 3'd1));
        sum    = sum >>> sh;
        f_lane = sum[DW-1:0];
      end
      default: f_lane = x;
    endcase
  endfunction

  function automatic logic [LOG2_DEPTH-1:0] f_next(input logic [LOG2_DEPTH-1:0] p);
    f_next = (p == LOG2_DEPTH'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_acc     = bus.in_vld & bus.in_rdy;
  assign w_out_vld = (r_count != '0);
  assign w_pop     = w_out_vld & bus.out_rdy;
  assign w_wr      = r_pvld[LAT-1];

  assign bus.in_rdy  = r_busy & (r_credit != '0) & (r_in_cnt != r_num);
  assign bus.out_vld = w_out_vld;
  assign bus.out_dat = w_out_vld ? r_mem[r_rptr] : '0;
  assign busy        = r_busy;
  assign done        = r_done;

  // Elementwise function applied to every lane with the latched job settings
  always_comb begin
    w_f = '0;
    for (int unsigned i = 0; i < LANES; i++)
      w_f[i*DW +: DW] = f_lane(bus.in_dat[i*DW +: DW], r_mode, r_shift);
  end

  // Job control: start latching, input/output counters, done/busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_mode    <= '0;
      r_shift   <= '0;
      r_num     <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      if (start && !r_busy) begin
        r_mode    <= mode;
        r_shift   <= shift;
        r_num     <= num_vec;
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
        if (num_vec == 16'd0) r_done <= 1'b1;
        else                  r_busy <= 1'b1;
      end else if (r_busy) begin
        if (w_acc) r_in_cnt <= r_in_cnt + 16'd1;
        if (w_pop) begin
          r_out_cnt <= r_out_cnt + 16'd1;
          if (r_out_cnt + 16'd1 == r_num) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
      end
    end
  end

  // Credit: free FIFO slots minus vectors still in the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_credit <= CW'(FIFO_DEPTH);
    else begin
      case ({w_acc, w_pop})
        2'b10:   r_credit <= r_credit - 1'b1;
        2'b01:   r_credit <= r_credit + 1'b1;
        default: r_credit <= r_credit;
      endcase
    end
  end

  // Fixed-latency pipeline, no stalls; stage 0 holds f(in_dat)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pvld <= '0;
      for (int unsigned i = 0; i < LAT; i++) r_pdat[i] <= '0;
    end else begin
      r_pvld[0] <= w_acc;
      r_pdat[0] <= w_f;
      for (int unsigned i = 1; i < LAT; i++) begin
        r_pvld[i] <= r_pvld[i-1];
        r_pdat[i] <= r_pdat[i-1];
      end
    end
  end

  // FIFO storage; space is guaranteed by the credit so writes are unconditional
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_pdat[LAT-1];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wptr <= f_next(r_wptr);
      if (w_pop) r_rptr <= f_next(r_rptr);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_act_lane_pipe.sv
// Directed/scoreboard bench for act_lane_pipe.
module tb_act_lane_pipe;
  localparam int LANES = 8;
  localparam int DW    = 16;
  localparam int LAT   = 4;
  localparam int FD    = 8;
  localparam int L2    = 3;

  localparam logic [127:0] VIN  = {16'hFFF0,16'h0010,16'hFFF9,16'h0006,16'h7FFF,16'h0000,16'hFFFF,16'h8000};
  localparam logic [127:0] EXP1 = {16'h0000,16'h0010,16'h0000,16'h0006,16'h7FFF,16'h0000,16'h0000,16'h0000};
  localparam logic [127:0] EXP2 = {16'hFFFE,16'h0010,16'hFFFF,16'h0006,16'h7FFF,16'h0000,16'hFFFF,16'hF000};
  localparam logic [127:0] EXP3 = {16'hFFFC,16'h0004,16'hFFFE,16'h0002,16'h2000,16'h0000,16'h0000,16'hE000};

  logic        clk, rst_n, start, busy, done;
  logic [1:0]  mode;
  logic [2:0]  shift;
  logic [15:0] num_vec;

  int n_tests = 0;
  int n_fail  = 0;

  int acc, pop, dn, rdy_n, first_acc, first_vld;
  logic [127:0] last_out;
  logic [127:0] sb [$];

  act_lane_pipe_if #(.LANES(LANES), .DW(DW)) bus ();

  act_lane_pipe #(
    .LANES(LANES), .DW(DW), .LAT(LAT), .FIFO_DEPTH(FD), .LOG2_DEPTH(L2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .shift(shift),
    .num_vec(num_vec), .bus(bus), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_lane(input logic [15:0] x, input int m, input int sh);
    int v;
    int r;
    v = $signed(x);
    case (m)
      1:       r = (v < 0) ? 0 : v;
      2:       r = (v < 0) ? (v >>> 3) : v;
      3:       r = (sh == 0) ? v : ((v + (1 << (sh - 1))) >>> sh);
      default: r = v;
    endcase
    return r[15:0];
  endfunction

  function automatic logic [127:0] model_vec(input logic [127:0] x, input int m, input int sh);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*16 +: 16] = model_lane(x[i*16 +: 16], m, sh);
    return r;
  endfunction

  task automatic start_job(input int n, input int m, input int sh);
    start   = 1'b1;
    mode    = 2'(m);
    shift   = 3'(sh);
    num_vec = 16'(n);
    tick();
    start   = 1'b0;
  endtask

  task automatic run_job(input int n, input int m, input int sh, input int vld_pct,
                         input int rdy_pct, input int hold, input int restart_at,
                         input bit use_fixed, input logic [127:0] fvec);
    int budget;
    bit fin;
    budget = n * 8 + hold + 60;
    fin = 0;
    sb.delete();
    acc = 0; pop = 0; dn = 0; rdy_n = 0; first_acc = -1; first_vld = -1;
    start_job(n, m, sh);
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      bus.in_vld  = ($urandom_range(99) < vld_pct);
      bus.in_dat  = use_fixed ? fvec : {$urandom, $urandom, $urandom, $urandom};
      bus.out_rdy = (cyc < hold) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      if (cyc == restart_at) begin
        start = 1'b1; num_vec = 16'd2; mode = 2'd1;
      end
      if (done) begin
        dn++;
        check("busy_at_done", busy, 1'b0);
        fin = 1;
      end
      if (hold > 0 && cyc == hold) begin
        check("hold_accepts", acc, FD);
        check("hold_in_rdy", bus.in_rdy, 1'b0);
      end
      check("credit_inv", int'(dut.r_credit) + $countones(dut.r_pvld) + int'(dut.r_count), FD);
      if (bus.in_rdy) rdy_n++;
      if (bus.in_vld && bus.in_rdy) begin
        sb.push_back(model_vec(bus.in_dat, m, sh));
        acc++;
        if (first_acc < 0) first_acc = cyc;
      end
      if (bus.out_vld && first_vld < 0) first_vld = cyc;
      if (bus.out_vld && bus.out_rdy) begin
        last_out = bus.out_dat;
        if (sb.size() == 0) check("sb_underflow", 1, 0);
        else                check("data", bus.out_dat, sb.pop_front());
        pop++;
      end
      tick();
      start = 1'b0;
    end
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b0;
    if (!fin) check("timeout", 0, 1);
    check("accepts", acc, n);
    check("pops", pop, n);
    check("done_cnt", dn, 1);
    check("sb_left", sb.size(), 0);
    check("credit_end", dut.r_credit, FD);
    check("done_pulse", done, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = '0; shift = '0; num_vec = '0;
    bus.in_vld = 1'b0; bus.in_dat = '0; bus.out_rdy = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_in_rdy", bus.in_rdy, 1'b0);
    check("rst_out_vld", bus.out_vld, 1'b0);
    check("rst_out_dat", bus.out_dat, '0);
    check("rst_credit", dut.r_credit, FD);
    rst_n = 1'b1;
    tick();

    // Basic bypass job with full throughput
    run_job(4, 0, 0, 100, 100, 0, -1, 0, '0);
    check("t1_rdy_cycles", rdy_n, 4);
    check("t1_first_acc", first_acc, 0);
    check("t1_latency", first_vld - first_acc, LAT + 1);

    // Lane functions against hand-computed vectors
    run_job(1, 1, 0, 100, 100, 0, -1, 1, VIN);
    check("mode1_vec", last_out, EXP1);
    run_job(1, 2, 0, 100, 100, 0, -1, 1, VIN);
    check("mode2_vec", last_out, EXP2);
    run_job(1, 3, 2, 100, 100, 0, -1, 1, VIN);
    check("mode3_vec", last_out, EXP3);
    run_job(1, 3, 0, 100, 100, 0, -1, 1, VIN);
    check("mode3_sh0_vec", last_out, VIN);
    run_job(1, 0, 0, 100, 100, 0, -1, 1, VIN);
    check("mode0_vec", last_out, VIN);

    // Backpressure: FIFO fills to exactly FD, then drains without loss
    run_job(20, 0, 0, 100, 100, 30, -1, 0, '0);

    // Start during busy is ignored
    run_job(12, 2, 0, 100, 100, 0, 3, 0, '0);

    // Random handshakes
    run_job(200, 2, 0, 50, 50, 0, -1, 0, '0);
    run_job(1000, 3, 5, 50, 50, 0, -1, 0, '0);

    // Zero-length job
    start_job(0, 0, 0);
    check("nv0_done", done, 1'b1);
    check("nv0_busy", busy, 1'b0);
    check("nv0_in_rdy", bus.in_rdy, 1'b0);
    tick();
    check("nv0_done_drop", done, 1'b0);
    check("nv0_busy_after", busy, 1'b0);

    // Reset in the middle of a job
    start_job(10, 0, 0);
    bus.in_vld = 1'b1; bus.out_rdy = 1'b0; bus.in_dat = VIN;
    repeat (6) tick();
    check("mid_out_vld_pre", bus.out_vld, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_in_rdy", bus.in_rdy, 1'b0);
    check("mid_rst_out_vld", bus.out_vld, 1'b0);
    check("mid_rst_out_dat", bus.out_dat, '0);
    check("mid_rst_credit", dut.r_credit, FD);
    bus.in_vld = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_job(5, 3, 3, 100, 100, 0, -1, 0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/act_lane_pipe.md
Name: act_lane_pipe

Overview:
- Parametrised multi-lane activation stage for the matrix/ACT path: sits between the read-side data buffer and the write DMA.
- Applies a run-time-selectable elementwise function (bypass, ReLU, leaky-ReLU, rounding requantise shift) to LANES signed lanes through a fixed LAT-stage pipeline.
- Feeds a credit-protected output FIFO, so downstream backpressure never drops data.
- A start/done frame counter bounds each job to num_vec vectors.

Parameters:
- LANES, 8, number of parallel lanes per vector
- DW, 16, signed lane width in bits
- LAT, 4, pipeline latency in cycles (>=1)
- FIFO_DEPTH, 8, output FIFO entries; must be >= LAT+2 for full throughput
- LOG2_DEPTH, 3, clog2(FIFO_DEPTH)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle job start pulse
- mode  in  2  0 bypass, 1 ReLU, 2 leaky-ReLU, 3 requantise
- shift  in  3  right-shift amount for mode 3
- num_vec  in  16  vectors in this job
- in_vld  in  1  input vector valid
- in_rdy  out  1  input vector accepted when in_vld&in_rdy
- in_dat  in  LANES*DW  input lanes; lane i at [i*DW+:DW]
- out_vld  out  1  output FIFO head valid
- out_rdy  in  1  downstream pop
- out_dat  out  LANES*DW  output lanes
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end

Behaviour:
- Reset values:
  - busy=0, done=0, in_rdy=0, out_vld=0, out_dat=0.
  - Pipeline valids cleared; FIFO empty; credit=FIFO_DEPTH; counters=0.
  - Reset mid-job discards all in-flight and FIFO data.
- Start:
  - start while busy=0 latches mode, shift and num_vec, clears both counters, and sets busy next cycle.
  - start while busy=1 is ignored.
  - start with num_vec=0: done pulses the next cycle and busy stays 0.
- Credit:
  - credit counts free FIFO slots minus vectors in flight.
  - Decrements on accept; increments on pop (out_vld&out_rdy); unchanged when both happen in the same cycle.
  - Never exceeds FIFO_DEPTH and never goes below 0.
- in_rdy = busy & (credit!=0) & (in_cnt!=num_vec). It is combinational from registers only and independent of in_vld.
- Pipeline:
  - Stage 1 registers f(in_dat) per lane; stages 2..LAT carry data plus a valid bit. No stalls in the pipeline.
  - Result is written to the FIFO at edge t+LAT for an accept at edge t.
  - FIFO is first-word-fall-through: out_vld rises in the cycle after the write edge when the FIFO was empty.
- Lane function (x signed DW):
  - mode 0: y=x.
  - mode 1: y = x<0 ? 0 : x.
  - mode 2: y = x<0 ? x>>>3 (arithmetic) : x.
  - mode 3, shift=0: y=x.
  - mode 3, shift>0: y=(x + (1<<(shift-1)))>>>shift, computed at DW+1 bits then truncated to DW (cannot overflow).
- FIFO:
  - Write and pop in the same cycle are both honoured, including when full, because the credit guarantees space.
  - Pop when empty is ignored.
  - out_dat holds its value while out_vld=1 & out_rdy=0.
- Completion:
  - out_cnt increments on each pop.
  - On the pop that makes out_cnt==num_vec: done=1 in the next cycle and busy=0 in that same cycle.
  - A start in the done cycle is accepted, since busy=0.
- Throughput is 1 vector/cycle when out_rdy=1 and FIFO_DEPTH>=LAT+2.

Test Plan:
- Reset, then num_vec=4, mode=0, in_vld held 1, out_rdy=1:
  - in_rdy high for 4 accept cycles.
  - out_dat equals inputs in order.
  - First out_vld exactly LAT+1 cycles after the first accept edge.
  - done pulses once; busy falls in the same cycle.
- Modes 1, 2 and 3 (shift=2), lane values 0x8000, 0xFFFF, 0x0000, 0x7FFF, 0x0006, 0xFFF9:
  - mode1 -> 0, 0, 0, 0x7FFF, 6, 0
  - mode2 -> 0xF000, 0xFFFF, 0, 0x7FFF, 6, 0xFFFF
  - mode3 -> 0xE000, 0x0000, 0, 0x2000, 2, 0xFFFE
- out_rdy=0, num_vec=20, in_vld=1:
  - Exactly FIFO_DEPTH vectors accepted, then in_rdy=0.
  - Release out_rdy: all 20 vectors out, no loss or duplication.
  - credit returns to FIFO_DEPTH.
- Random in_vld/out_rdy (50% each), 1000 vectors:
  - Scoreboard exact match.
  - credit + in-flight + FIFO occupancy == FIFO_DEPTH every cycle.
- Edge starts:
  - start during busy -> ignored.
  - start with num_vec=0 -> done the next cycle, no in_rdy.
  - rst_n low mid-job -> all outputs return to reset values; a new job runs clean.
